// File: rtl/multi_channel_signal_generator.sv
// rtl/multi_channel_signal_generator.sv - double-buffered multi-channel pattern player
//
// Plays CHANNELS independent SIZE-bit patterns, one bit per CLK_PE tick.
// Each sweep is restarted by TRIG. A word-serial load port fills a shadow
// bank while the active bank plays. The banks swap on a TRIG that finds the
// shadow bank complete.
//
// Ports:
//   SYS_CLK, SYS_RSTN         clock, asynchronous active-low reset
//   EN[CHANNELS]              per-channel combinational output gate
//   MODE                      0 = one-shot sweep, 1 = continuous wrap
//   TRIG                      sweep restart / bank swap strobe
//   CLK_PE                    pattern advance strobe
//   LOAD_DATA/VALID/LAST      shadow-bank load stream, LOAD_READY back-pressure
//   GEN_SIGNAL[CHANNELS]      generated per-channel signal
//   BUSY                      sweep in progress
//   SHADOW_FULL               complete shadow bank waiting for TRIG
//   LOAD_ERR                  1-cycle pulse on load framing error
//   STALE                     1-cycle pulse when TRIG replays the old bank
module multi_channel_signal_generator #(
  parameter int CHANNELS = 4,
  parameter int SIZE     = 3200,
  parameter int WORD     = 32
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RSTN,
  input  logic [CHANNELS-1:0] EN,
  input  logic                MODE,
  input  logic                TRIG,
  input  logic                CLK_PE,
  input  logic [WORD-1:0]     LOAD_DATA,
  input  logic                LOAD_VALID,
  input  logic                LOAD_LAST,
  output logic                LOAD_READY,
  output logic [CHANNELS-1:0] GEN_SIGNAL,
  output logic                BUSY,
  output logic                SHADOW_FULL,
  output logic                LOAD_ERR,
  output logic                STALE
);

  localparam int WPC = (SIZE + WORD - 1) / WORD;
  localparam int IW  = $clog2(SIZE + 1);
  localparam int SW  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int KW  = (WPC > 1) ? $clog2(WPC) : 1;

  localparam logic [IW-1:0] IDLE_IDX = IW'(SIZE);
  localparam logic [IW-1:0] END_IDX  = IW'(SIZE - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);
  localparam logic [KW-1:0] WD_LAST  = KW'(WPC - 1);

  typedef enum logic {FILL, FULL} load_state_t;

  load_state_t   state;
  logic [IW-1:0] idx;
  logic [SW-1:0] idx_sel;
  logic [CW-1:0] ch_cnt;
  logic [KW-1:0] wd_cnt;
  logic          busy_int;
  logic          accept;
  logic          last_word;

  logic [SIZE-1:0] active [CHANNELS];
  logic [SIZE-1:0] shadow [CHANNELS];

  assign busy_int    = (idx < IDLE_IDX);
  assign idx_sel     = idx[SW-1:0];
  assign accept      = LOAD_VALID && (state == FILL);
  assign last_word   = (ch_cnt == CH_LAST) && (wd_cnt == WD_LAST);

  assign BUSY        = busy_int;
  assign LOAD_READY  = (state == FILL);
  assign SHADOW_FULL = (state == FULL);

  // The idle index is SIZE, which is out of range for the bank; busy_int
  // masks that case so the bit select is never used while idle.
  always_comb begin
    GEN_SIGNAL = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      GEN_SIGNAL[c] = EN[c] & busy_int & active[c][idx_sel];
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
    if (!SYS_RSTN) begin
      state    <= FILL;
      idx      <= IDLE_IDX;
      ch_cnt   <= '0;
      wd_cnt   <= '0;
      LOAD_ERR <= 1'b0;
      STALE    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        active[c] <= '0;
        shadow[c] <= '0;
      end
    end else begin
      LOAD_ERR <= 1'b0;
      STALE    <= 1'b0;

      // Sweep index: TRIG wins over a coincident CLK_PE.
      if (TRIG) begin
        idx <= '0;
      end else if (CLK_PE && busy_int) begin
        if (idx == END_IDX) begin
          idx <= MODE ? '0 : IDLE_IDX;
        end else begin
          idx <= idx + 1'b1;
        end
      end

      // Shadow fill. Bits of a channel's last word that fall at or beyond
      // SIZE have no storage and are simply not written.
      if (accept) begin
        for (int b = 0; b < WORD; b++) begin
          if (int'(wd_cnt) * WORD + b < SIZE) begin
            shadow[ch_cnt][SW'(int'(wd_cnt) * WORD + b)] <= LOAD_DATA[b];
          end
        end
        if (last_word && LOAD_LAST) begin
          state  <= FULL;
          ch_cnt <= '0;
          wd_cnt <= '0;
        end else if (last_word || LOAD_LAST) begin
          LOAD_ERR <= 1'b1;
          ch_cnt   <= '0;
          wd_cnt   <= '0;
        end else if (wd_cnt == WD_LAST) begin
          wd_cnt <= '0;
          ch_cnt <= ch_cnt + 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end

      // Swap decision uses the state before this edge. A final word arriving
      // together with TRIG therefore completes the bank but does not swap.
      if (TRIG) begin
        if (state == FULL) begin
          for (int c = 0; c < CHANNELS; c++) begin
            active[c] <= shadow[c];
          end
          state  <= FILL;
          ch_cnt <= '0;
          wd_cnt <= '0;
        end else begin
          STALE <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_signal_generator.sv
// tb/tb_multi_channel_signal_generator.sv - directed self-checking bench for multi_channel_signal_generator
module tb_multi_channel_signal_generator;

  logic       sys_clk = 1'b0;
  logic       sys_rstn = 1'b0;

  // Main instance: CHANNELS=4, SIZE=3200, WORD=32 (WPC=100)
  logic [3:0]  en = 4'hF;
  logic        mode = 1'b0;
  logic        trig = 1'b0;
  logic        clk_pe = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_valid = 1'b0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic [3:0]  gen_signal;
  logic        busy;
  logic        shadow_full;
  logic        load_err;
  logic        stale;

  // Small instance: CHANNELS=4, SIZE=33, WORD=32 (WPC=2)
  logic [3:0]  s_en = 4'hF;
  logic        s_trig = 1'b0;
  logic        s_clk_pe = 1'b0;
  logic [31:0] s_load_data = '0;
  logic        s_load_valid = 1'b0;
  logic        s_load_last = 1'b0;
  logic        s_load_ready;
  logic [3:0]  s_gen_signal;
  logic        s_busy;
  logic        s_shadow_full;
  logic        s_load_err;
  logic        s_stale;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  multi_channel_signal_generator #(.CHANNELS(4), .SIZE(3200), .WORD(32)) dut (
    .SYS_CLK(sys_clk), .SYS_RSTN(sys_rstn), .EN(en), .MODE(mode), .TRIG(trig),
    .CLK_PE(clk_pe), .LOAD_DATA(load_data), .LOAD_VALID(load_valid),
    .LOAD_LAST(load_last), .LOAD_READY(load_ready), .GEN_SIGNAL(gen_signal),
    .BUSY(busy), .SHADOW_FULL(shadow_full), .LOAD_ERR(load_err), .STALE(stale)
  );

  multi_channel_signal_generator #(.CHANNELS(4), .SIZE(33), .WORD(32)) dut_small (
    .SYS_CLK(sys_clk), .SYS_RSTN(sys_rstn), .EN(s_en), .MODE(1'b0), .TRIG(s_trig),
    .CLK_PE(s_clk_pe), .LOAD_DATA(s_load_data), .LOAD_VALID(s_load_valid),
    .LOAD_LAST(s_load_last), .LOAD_READY(s_load_ready), .GEN_SIGNAL(s_gen_signal),
    .BUSY(s_busy), .SHADOW_FULL(s_shadow_full), .LOAD_ERR(s_load_err), .STALE(s_stale)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // pat selects the one channel whose 100 words are non-zero:
  // 0 -> ch0 = 0xAAAAAAAA, 1 -> ch1 = all ones, 2 -> ch2 = all ones
  function automatic logic [31:0] word_val(input int pat, input int k);
    if (k / 100 != pat) return 32'h0;
    return (pat == 0) ? 32'hAAAA_AAAA : 32'hFFFF_FFFF;
  endfunction

  task automatic load_words(input int pat, input int n, input int last_at, input bit trig_last);
    for (int k = 0; k < n; k++) begin
      load_data  = word_val(pat, k);
      load_valid = 1'b1;
      load_last  = (k == last_at);
      trig       = trig_last && (k == n - 1);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    trig       = 1'b0;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      clk_pe = 1'b1;
      tick();
    end
    clk_pe = 1'b0;
  endtask

  initial begin
    int bad;

    // Reset, then CLK_PE pulses while idle must do nothing
    repeat (3) tick();
    sys_rstn = 1'b1;
    advance(4);
    check("rst_load_ready", load_ready, 1);
    check("rst_gen", gen_signal, 0);
    check("rst_busy", busy, 0);
    check("rst_shadow_full", shadow_full, 0);
    check("rst_flags", {load_err, stale}, 0);

    // Full load of pattern 0, then swap
    load_words(0, 400, 399, 1'b0);
    check("load0_shadow_full", shadow_full, 1);
    check("load0_ready", load_ready, 0);
    pulse_trig();
    check("swap0_busy", busy, 1);
    check("swap0_gen_idx0", gen_signal, 4'b0000);
    check("swap0_shadow_full", shadow_full, 0);
    check("swap0_stale", stale, 0);

    // One-shot sweep, CLK_PE every 4 cycles: ch0 alternates 0,1,0,1...
    bad = 0;
    for (int n = 1; n < 3200; n++) begin
      clk_pe = 1'b1;
      tick();
      clk_pe = 1'b0;
      if (gen_signal !== {3'b000, n[0]} || busy !== 1'b1) bad++;
      if (n == 1) begin
        en = 4'hE;
        #1;
        check("en_gate_ch0", gen_signal, 4'b0000);
        en = 4'hF;
        #1;
      end
      repeat (3) tick();
    end
    check("sweep0_bits", bad, 0);
    check("sweep0_last_gen", gen_signal, 4'b0001);
    advance(1);
    check("oneshot_end_busy", busy, 0);
    check("oneshot_end_gen", gen_signal, 0);
    advance(2);
    check("idle_pe_busy", busy, 0);

    // TRIG with nothing loaded: stale pulse, old bank replays, continuous wrap
    mode = 1'b1;
    pulse_trig();
    check("stale0_pulse", stale, 1);
    check("stale0_busy", busy, 1);
    advance(1);
    check("stale0_pulse_clear", stale, 0);
    check("stale0_replay_idx1", gen_signal, 4'b0001);
    advance(3198);
    check("wrap_idx3199", gen_signal, 4'b0001);
    advance(1);
    check("wrap_busy", busy, 1);
    check("wrap_idx0", gen_signal, 4'b0000);
    advance(1);
    check("wrap_idx1", gen_signal, 4'b0001);
    mode = 1'b0;
    advance(3198);
    check("mode_change_still_busy", busy, 1);
    advance(1);
    check("mode_change_end_busy", busy, 0);

    // Framing errors: missing LAST on final word, then LAST on word 10
    load_words(1, 400, -1, 1'b0);
    check("err_nolast_pulse", load_err, 1);
    check("err_nolast_shadow_full", shadow_full, 0);
    load_words(1, 11, 10, 1'b0);
    check("err_early_pulse", load_err, 1);
    check("err_early_ready", load_ready, 1);
    tick();
    check("err_pulse_clear", load_err, 0);
    load_words(1, 400, 399, 1'b0);
    check("reload_shadow_full", shadow_full, 1);
    check("reload_err", load_err, 0);
    pulse_trig();
    check("swap1_gen", gen_signal, 4'b0010);
    pulse_trig();
    check("stale1_pulse", stale, 1);
    check("stale1_old_bank", gen_signal, 4'b0010);

    // TRIG coincident with the final word: completes bank, no swap yet
    load_words(2, 400, 399, 1'b1);
    check("coinc_stale", stale, 1);
    check("coinc_shadow_full", shadow_full, 1);
    check("coinc_old_bank", gen_signal, 4'b0010);
    pulse_trig();
    check("coinc_swap_gen", gen_signal, 4'b0100);
    check("coinc_swap_shadow_full", shadow_full, 0);
    check("coinc_swap_stale", stale, 0);

    // SIZE=33 instance: bits above position 32 in each word 1 are garbage
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: s_load_data = 32'h5555_5555;
        1: s_load_data = 32'hFFFF_FFFE;
        3: s_load_data = 32'hFFFF_FFFF;
        5, 7: s_load_data = 32'hAAAA_AAAA;
        default: s_load_data = 32'h0;
      endcase
      s_load_valid = 1'b1;
      s_load_last  = (k == 7);
      tick();
    end
    s_load_valid = 1'b0;
    s_load_last  = 1'b0;
    check("small_shadow_full", s_shadow_full, 1);
    s_trig = 1'b1;
    tick();
    s_trig = 1'b0;
    check("small_idx0", s_gen_signal, 4'b0001);
    for (int i = 0; i < 32; i++) begin
      s_clk_pe = 1'b1;
      tick();
    end
    s_clk_pe = 1'b0;
    check("small_idx32", s_gen_signal, 4'b0010);
    s_clk_pe = 1'b1;
    tick();
    s_clk_pe = 1'b0;
    check("small_end_busy", s_busy, 0);
    check("small_end_gen", s_gen_signal, 0);

    // Asynchronous reset mid-sweep
    advance(5);
    check("pre_rst_busy", busy, 1);
    #2;
    sys_rstn = 1'b0;
    #1;
    check("async_rst_gen", gen_signal, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", load_ready, 1);
    tick();
    sys_rstn = 1'b1;
    pulse_trig();
    check("post_rst_stale", stale, 1);
    check("post_rst_bank_clear", gen_signal, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
